// File: rtl/imm_decode_stage_pkg.sv
// Shared RISC-V decode definitions for the immediate-decode stage.
//   - base opcode constants (instr[6:0])
//   - immediate format codes carried on out_fmt
//   - small helper to recognise the OP-IMM shift funct3 encodings
// No ports: this is a package imported by imm_extract and imm_decode_stage.
package imm_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6,
        FMT_X = 3'd7
    } imm_fmt_e;

    // SLLI (001) and SRLI/SRAI (101) carry a shift amount instead of an immediate.
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// imm_extract: combinational immediate decoder.
// Classifies an instruction word into an immediate format and produces the
// XLEN-wide extended immediate, plus an illegal-opcode flag.
// Ports:
//   instr    in   32    instruction word
//   fmt      out  3     format code (imm_fmt_e encoding)
//   imm      out  XLEN  sign-/zero-extended immediate
//   illegal  out  1     opcode not recognised (includes instr[1:0] != 2'b11)
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit ZIMM_EN = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    // Raw immediate fields, declared signed so a size cast sign-extends them.
    logic signed [11:0] i_field;
    logic signed [11:0] s_field;
    logic signed [12:0] b_field;
    logic signed [31:0] u_field;
    logic signed [20:0] j_field;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign i_field = instr[31:20];
    assign s_field = {instr[31:25], instr[11:7]};
    assign b_field = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_field = {instr[31:12], 12'b0};
    assign j_field = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        fmt     = FMT_X;
        imm     = '0;
        illegal = 1'b0;
        // Opcodes with instr[1:0] != 2'b11 never match below, so they fall
        // into the illegal default.
        case (opcode)
            OPC_OP_IMM: begin
                fmt = FMT_I;
                if (is_shift_funct3(funct3)) begin
                    if (XLEN == 64) imm = XLEN'(instr[25:20]);
                    else            imm = XLEN'(instr[24:20]);
                end else begin
                    imm = XLEN'(i_field);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'(i_field);
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt = FMT_I;
                    // Word shifts only ever use a 5-bit shift amount.
                    if (is_shift_funct3(funct3)) imm = XLEN'(instr[24:20]);
                    else                         imm = XLEN'(i_field);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'(s_field);
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'(b_field);
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'(u_field);
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'(j_field);
            end
            OPC_SYSTEM: begin
                if (ZIMM_EN && funct3[2]) begin
                    fmt = FMT_Z;
                    imm = XLEN'(instr[19:15]);
                end else begin
                    // CSR address is an unsigned 12-bit number.
                    fmt = FMT_I;
                    imm = XLEN'(instr[31:20]);
                end
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            OPC_OP_32: begin
                if (XLEN == 64) fmt = FMT_R;
                else            illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered, flow-controlled immediate decode between
// fetch and register-read. Decodes on the input path and stores decoded
// results in a 2-entry FIFO whose head drives out_*.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and a presented entry holds every out_*
// value stable until it is taken.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   flush            synchronous kill of all buffered entries (highest priority)
//   in_valid/ready   upstream handshake; in_instr, in_pc carried with it
//   out_valid/ready  downstream handshake
//   out_imm, out_fmt, out_pc, out_illegal   decoded head entry
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit ZIMM_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_extract #(
        .XLEN    (XLEN),
        .ZIMM_EN (ZIMM_EN)
    ) u_imm_extract (
        .instr   (in_instr),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0] imm_mem [2];
    logic [XLEN-1:0] pc_mem  [2];
    logic [2:0]      fmt_mem [2];
    logic            ill_mem [2];

    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       ready_q;
    logic       push;
    logic       pop;

    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & ready_q & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_mem[i] <= '0;
                pc_mem[i]  <= '0;
                fmt_mem[i] <= FMT_R;
                ill_mem[i] <= 1'b0;
            end
        end else begin
            // in_ready is the registered complement of "full next cycle".
            ready_q <= (count_next != 2'd2);
            count   <= count_next;
            if (flush) begin
                // Empty the FIFO by collapsing the write pointer onto the head;
                // the head slot is untouched so out_imm/fmt/pc keep their value.
                wr_ptr <= rd_ptr;
            end else begin
                if (push) begin
                    imm_mem[wr_ptr] <= dec_imm;
                    pc_mem[wr_ptr]  <= in_pc;
                    fmt_mem[wr_ptr] <= dec_fmt;
                    ill_mem[wr_ptr] <= dec_illegal;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    assign out_imm     = imm_mem[rd_ptr];
    assign out_pc      = pc_mem[rd_ptr];
    assign out_fmt     = fmt_mem[rd_ptr];
    assign out_illegal = ill_mem[rd_ptr];

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        in_ready_32, out_valid_32, out_illegal_32;
    logic [31:0] out_imm_32, out_pc_32;
    logic [2:0]  out_fmt_32;

    logic        in_ready_64, out_valid_64, out_illegal_64;
    logic [63:0] out_imm_64, out_pc_64;
    logic [2:0]  out_fmt_64;

    int checks = 0;
    int errors = 0;

    imm_decode_stage #(.XLEN(32), .ZIMM_EN(1'b1)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready_32),
        .in_instr    (in_instr),
        .in_pc       (pc32),
        .out_valid   (out_valid_32),
        .out_ready   (out_ready),
        .out_imm     (out_imm_32),
        .out_fmt     (out_fmt_32),
        .out_pc      (out_pc_32),
        .out_illegal (out_illegal_32)
    );

    imm_decode_stage #(.XLEN(64), .ZIMM_EN(1'b1)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready_64),
        .in_instr    (in_instr),
        .in_pc       (pc64),
        .out_valid   (out_valid_64),
        .out_ready   (out_ready),
        .out_imm     (out_imm_64),
        .out_fmt     (out_fmt_64),
        .out_pc      (out_pc_64),
        .out_illegal (out_illegal_64)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        pc32     = pc;
        pc64     = {32'h0, pc};
    endtask

    task automatic expect32(input string tag, input logic v, input logic [31:0] imm,
                            input logic [2:0] fmt, input logic [31:0] pc, input logic ill);
        check({tag, ".valid"}, 64'(out_valid_32), 64'(v));
        check({tag, ".imm"},   64'(out_imm_32),   64'(imm));
        check({tag, ".fmt"},   64'(out_fmt_32),   64'(fmt));
        check({tag, ".pc"},    64'(out_pc_32),    64'(pc));
        check({tag, ".ill"},   64'(out_illegal_32), 64'(ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // reset state
        #12;
        expect32("reset", 1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
        check("reset.in_ready", 64'(in_ready_32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset.in_ready", 64'(in_ready_32), 64'd1);

        // directed decode vectors, out_ready=1, one entry in flight
        drive(1'b1, 32'hFFB10093, 32'h1000); step();
        expect32("addi", 1'b1, 32'hFFFFFFFB, 3'd1, 32'h1000, 1'b0);
        check("addi.imm64", out_imm_64, 64'hFFFFFFFFFFFFFFFB);

        drive(1'b1, 32'hFE208EE3, 32'h1004); step();
        expect32("beq", 1'b1, 32'hFFFFFFFC, 3'd3, 32'h1004, 1'b0);

        drive(1'b1, 32'h300FD0F3, 32'h1008); step();
        expect32("csrrwi", 1'b1, 32'h0000001F, 3'd6, 32'h1008, 1'b0);

        drive(1'b1, 32'h800000B7, 32'h100C); step();
        check("lui.imm32", 64'(out_imm_32), 64'h80000000);
        check("lui.imm64", out_imm_64, 64'hFFFFFFFF80000000);
        check("lui.fmt64", 64'(out_fmt_64), 64'd4);

        drive(1'b1, 32'h03F09093, 32'h1010); step();
        check("slli.imm64", out_imm_64, 64'd63);
        check("slli.imm32", 64'(out_imm_32), 64'd31);
        check("slli.fmt64", 64'(out_fmt_64), 64'd1);

        drive(1'b1, 32'hFE20AC23, 32'h1014); step();
        expect32("sw", 1'b1, 32'hFFFFFFF8, 3'd2, 32'h1014, 1'b0);

        drive(1'b1, 32'hFF9FF06F, 32'h1018); step();
        expect32("jal", 1'b1, 32'hFFFFFFF8, 3'd5, 32'h1018, 1'b0);

        drive(1'b1, 32'hF14020F3, 32'h101C); step();
        expect32("csrrs", 1'b1, 32'h00000F14, 3'd1, 32'h101C, 1'b0);

        drive(1'b1, 32'h002081B3, 32'h1020); step();
        expect32("add", 1'b1, 32'h0, 3'd0, 32'h1020, 1'b0);

        drive(1'b1, 32'h00000000, 32'h1024); step();
        expect32("zero", 1'b1, 32'h0, 3'd7, 32'h1024, 1'b1);

        drive(1'b1, 32'hFFF0009B, 32'h1028); step();
        check("addiw.fmt32", 64'(out_fmt_32), 64'd7);
        check("addiw.ill32", 64'(out_illegal_32), 64'd1);
        check("addiw.fmt64", 64'(out_fmt_64), 64'd1);
        check("addiw.imm64", out_imm_64, 64'hFFFFFFFFFFFFFFFF);
        check("addiw.ill64", 64'(out_illegal_64), 64'd0);

        drive(1'b0, 32'h0, 32'h0); step();
        check("drain.valid", 64'(out_valid_32), 64'd0);

        // backpressure: three back-to-back inputs with out_ready=0
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h2000); step();
        check("bp.ready_after_1", 64'(in_ready_32), 64'd1);
        drive(1'b1, 32'h00200093, 32'h2004); step();
        check("bp.ready_after_2", 64'(in_ready_32), 64'd0);
        expect32("bp.head", 1'b1, 32'd1, 3'd1, 32'h2000, 1'b0);
        drive(1'b1, 32'h00300093, 32'h2008); step();
        check("bp.still_full", 64'(in_ready_32), 64'd0);
        expect32("bp.stable", 1'b1, 32'd1, 3'd1, 32'h2000, 1'b0);
        out_ready = 1'b1; step();
        expect32("bp.second", 1'b1, 32'd2, 3'd1, 32'h2004, 1'b0);
        check("bp.ready_reopen", 64'(in_ready_32), 64'd1);
        step();
        expect32("bp.third", 1'b1, 32'd3, 3'd1, 32'h2008, 1'b0);
        drive(1'b0, 32'h0, 32'h0); step();
        check("bp.empty", 64'(out_valid_32), 64'd0);

        // flush with two entries and an input presented
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 32'h3000); step();
        drive(1'b1, 32'h00600093, 32'h3004); step();
        check("fl.full", 64'(in_ready_32), 64'd0);
        drive(1'b1, 32'h00700093, 32'h3008);
        flush = 1'b1; step();
        check("fl.valid", 64'(out_valid_32), 64'd0);
        check("fl.in_ready", 64'(in_ready_32), 64'd1);
        check("fl.imm_kept", 64'(out_imm_32), 64'd5);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0); step();
        check("fl.stay_empty", 64'(out_valid_32), 64'd0);

        // flush while an input transfer is accepted: that input is discarded
        drive(1'b1, 32'h00800093, 32'h3010); step();
        check("fl2.one", 64'(out_valid_32), 64'd1);
        drive(1'b1, 32'h00900093, 32'h3014);
        flush = 1'b1; step();
        check("fl2.valid", 64'(out_valid_32), 64'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0); step();
        check("fl2.discarded", 64'(out_valid_32), 64'd0);

        // asynchronous reset mid-stream
        drive(1'b1, 32'h00A00093, 32'h4000); step();
        drive(1'b0, 32'h0, 32'h0);
        check("ar.before", 64'(out_valid_32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 64'(out_valid_32), 64'd0);
        check("ar.imm", 64'(out_imm_32), 64'd0);
        check("ar.in_ready", 64'(in_ready_32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar.ready_back", 64'(in_ready_32), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
